ravenoc_out_arbiter: RTL and testbench
======================================

// Module: ravenoc_out_arbiter
// PURPOSE
//  Output-port arbiter for a RaveNoC router. Shares one output link between N_PORTS input
//  modules using wormhole switching. A head flit locks the output to one input port until
//  that port's tail flit is accepted. Round-robin selection among heads; one registered
//  output stage towards the link/next router.
// PARAMETERS
//  N_PORTS         5    number of requesting input ports (>=1)
//  FLIT_WIDTH      34   flit width; bits [FLIT_WIDTH-1:FLIT_WIDTH-2] = flit type
//  N_VIRT_CHN      2    virtual channels; VCW = max(1,$clog2(N_VIRT_CHN))
//  TIMEOUT_CYCLES  256  lock watchdog limit (used only with RAVENOC_ARB_TIMEOUT_EN)
// PORTS
//  clk             in   1                  clock
//  arst            in   1                  async reset, active-low
//  req_flit_i      in   N_PORTS*FLIT_WIDTH port p at [p*FLIT_WIDTH +: FLIT_WIDTH]
//  req_vc_i        in   N_PORTS*VCW        VC id per port
//  req_valid_i     in   N_PORTS            flit valid per port
//  req_ready_o     out  N_PORTS            flit accepted per port
//  flit_data_o     out  FLIT_WIDTH         registered output flit
//  vc_id_o         out  VCW                registered output VC id
//  valid_o         out  1                  output flit valid
//  ready_i         in   1                  downstream ready
//  grant_o         out  N_PORTS            one-hot locked port, 0 when idle
//  busy_o          out  1                  1 while a packet holds the lock
//  lock_timeout_o  out  1                  watchdog pulse (only with RAVENOC_ARB_TIMEOUT_EN)
// BEHAVIOUR
//  - Flit type: 2'b00 head, 2'b01 body, 2'b10 tail, 2'b11 head+tail (single-flit packet).
//  - Reset (arst low): valid_o=0, flit_data_o=0, vc_id_o=0, grant_o=0, busy_o=0,
//    lock_timeout_o=0, state=IDLE, rr_ptr=N_PORTS-1 (port 0 has first priority).
//  - Output register: slot_free = !valid_o | ready_i. On accept, load flit/vc, valid_o=1
//    next cycle; else if ready_i, valid_o<=0. Latency input accept -> valid_o = 1 cycle.
//    Output fields held stable while valid_o & !ready_i.
//  - Accept on port p = req_valid_i[p] & req_ready_o[p]; at most one ready bit set per cycle.
//  - IDLE: candidates = ports with valid and type 00/11. Winner is first candidate
//    searching rr_ptr+1, rr_ptr+2, ... modulo N_PORTS (combinational, same cycle).
//    req_ready_o[winner] = slot_free. Valid body/tail in IDLE: never ready (held, not dropped).
//    Type 11 accepted: stay IDLE, rr_ptr<=winner. Type 00 accepted: -> LOCKED,
//    lock_port<=winner, grant_o/busy_o asserted from next cycle.
//  - LOCKED: only req_ready_o[lock_port] = slot_free; all other ports 0. Any type except
//    10 is forwarded as body (head mid-packet not re-arbitrated). Tail accepted: -> IDLE,
//    rr_ptr<=lock_port, grant_o/busy_o clear next cycle; new head arbitration starts that cycle.
//  - Back-to-back: a tail and next winner's head never share a cycle; max one flit/cycle.
//  - Simultaneous heads: only winner sees ready; losers hold valid until granted.
//  - ready_i low indefinitely: no loss, no duplication, no reordering within a port.
//  - Reset mid-packet: lock and in-flight output flit discarded; upstream resends.
//  - N_PORTS=1: rr_ptr width 1, port 0 always wins.
// CONFIGURATION
//  RAVENOC_ARB_TIMEOUT_EN defined: counter (width $clog2(TIMEOUT_CYCLES)+1) runs in LOCKED
//    while lock_port has no accepted flit; cleared on every accept and on entering LOCKED.
//    When it reaches TIMEOUT_CYCLES: lock_timeout_o=1 for one cycle, state->IDLE,
//    rr_ptr<=lock_port, grant_o/busy_o clear. Output register content unaffected.
//  Not defined: lock_timeout_o port, counter and parameter use absent; lock held forever.
// TESTING
//  1. Port 2 single-flit (type 11, payload 0xABC), idle, ready_i=1 -> valid_o next cycle,
//     flit_data_o matches, busy_o stays 0, rr_ptr=2.
//  2. Ports 0,1 heads same cycle, 3-flit packets H/B/T -> out order P0H,P0B,P0T,P1H,P1B,P1T;
//     grant_o=00001 then 00010; no interleave.
//  3. All 5 ports stream type-11 flits continuously, ready_i=1 -> output port order
//     0,1,2,3,4,0,... one flit per cycle.
//  4. ready_i=0 for 5 cycles after P0 body -> valid_o=1 and flit stable, req_ready_o=0,
//     P0 tail emerges 1 cycle after ready_i rises.
//  5. arst low after P3 head accepted -> all outputs 0; then heads on P0,P3 -> P0 wins.
//  6. (RAVENOC_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16) P1 head then valid low 16 cycles ->
//     lock_timeout_o pulse, busy_o=0, waiting P2 head accepted next cycle.

Source files
------------

// File: rtl/ravenoc_out_arbiter.sv
// Wormhole output-port arbiter: round-robin head selection, per-packet lock, one output register.
// Optional lock watchdog enabled by defining RAVENOC_ARB_TIMEOUT_EN.
module ravenoc_out_arbiter #(
  parameter int N_PORTS        = 5,
  parameter int FLIT_WIDTH     = 34,
  parameter int N_VIRT_CHN     = 2,
`ifdef RAVENOC_ARB_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 256,
`endif
  localparam int VCW = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic [N_PORTS*FLIT_WIDTH-1:0] req_flit_i,
  input  logic [N_PORTS*VCW-1:0]        req_vc_i,
  input  logic [N_PORTS-1:0]            req_valid_i,
  output logic [N_PORTS-1:0]            req_ready_o,
  output logic [FLIT_WIDTH-1:0]         flit_data_o,
  output logic [VCW-1:0]                vc_id_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [N_PORTS-1:0]            grant_o,
  output logic                          busy_o
`ifdef RAVENOC_ARB_TIMEOUT_EN
  ,
  output logic                          lock_timeout_o
`endif
);

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [1:0] FT_BODY   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]           lock_port_q, lock_port_d;
  logic [FLIT_WIDTH-1:0]   flit_q, flit_d;
  logic [VCW-1:0]          vc_q, vc_d;
  logic                    valid_q, valid_d;

  logic [FLIT_WIDTH-1:0]   in_flit [N_PORTS];
  logic [VCW-1:0]          in_vc   [N_PORTS];
  logic [1:0]              in_type [N_PORTS];
  logic [N_PORTS-1:0]      head_cand;
  logic                    win_found;
  logic [PW-1:0]           win_idx;
  logic                    slot_free;
  logic [PW-1:0]           sel;
  logic                    accept;

`ifdef RAVENOC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0]           wd_cnt_q, wd_cnt_d;
  logic                    timeout_q, timeout_d;
`endif

  // Heads (00) and single-flit packets (11) are the only flits that may win arbitration.
  for (genvar p = 0; p < N_PORTS; p++) begin : g_unpack
    assign in_flit[p]   = req_flit_i[p*FLIT_WIDTH +: FLIT_WIDTH];
    assign in_vc[p]     = req_vc_i[p*VCW +: VCW];
    assign in_type[p]   = req_flit_i[p*FLIT_WIDTH + FLIT_WIDTH - 2 +: 2];
    assign head_cand[p] = req_valid_i[p] && (in_type[p][1] == in_type[p][0]);
  end

  always_comb begin : arb_search
    int unsigned idx;
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int i = 1; i <= N_PORTS; i++) begin
      idx = (int'(rr_ptr_q) + i) % N_PORTS;
      if (!win_found && head_cand[idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
  end

  assign slot_free = !valid_q || ready_i;
  assign sel       = (state_q == LOCKED) ? lock_port_q : win_idx;

  always_comb begin
    req_ready_o = '0;
    if (state_q == LOCKED)  req_ready_o[lock_port_q] = slot_free;
    else if (win_found)     req_ready_o[win_idx]     = slot_free;
  end

  assign accept = |(req_valid_i & req_ready_o);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_port_d = lock_port_q;
    flit_d      = flit_q;
    vc_d        = vc_q;
    valid_d     = valid_q;

    if (accept) begin
      flit_d  = in_flit[sel];
      vc_d    = in_vc[sel];
      valid_d = 1'b1;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_type[sel] == FT_SINGLE) begin
            rr_ptr_d = win_idx;
          end else begin
            state_d     = LOCKED;
            lock_port_d = win_idx;
          end
        end
      end
      LOCKED: begin
        if (accept) begin
          if (in_type[sel] == FT_TAIL) begin
            state_d  = IDLE;
            rr_ptr_d = lock_port_q;
          end else begin
            // A stray head mid-packet is carried as payload, never re-arbitrated.
            flit_d[FLIT_WIDTH-1 -: 2] = FT_BODY;
          end
        end
      end
    endcase

`ifdef RAVENOC_ARB_TIMEOUT_EN
    wd_cnt_d  = '0;
    timeout_d = 1'b0;
    if (state_q == LOCKED && !accept) begin
      if (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        timeout_d = 1'b1;
        state_d   = IDLE;
        rr_ptr_d  = lock_port_q;
      end else begin
        wd_cnt_d = wd_cnt_q + 1'b1;
      end
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= PW'(N_PORTS - 1);
      lock_port_q <= '0;
      flit_q      <= '0;
      vc_q        <= '0;
      valid_q     <= 1'b0;
`ifdef RAVENOC_ARB_TIMEOUT_EN
      wd_cnt_q    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_port_q <= lock_port_d;
      flit_q      <= flit_d;
      vc_q        <= vc_d;
      valid_q     <= valid_d;
`ifdef RAVENOC_ARB_TIMEOUT_EN
      wd_cnt_q    <= wd_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign flit_data_o = flit_q;
  assign vc_id_o     = vc_q;
  assign valid_o     = valid_q;
  assign busy_o      = (state_q == LOCKED);

  always_comb begin
    grant_o = '0;
    if (state_q == LOCKED) grant_o[lock_port_q] = 1'b1;
  end

`ifdef RAVENOC_ARB_TIMEOUT_EN
  assign lock_timeout_o = timeout_q;
`endif

endmodule

// File: tb/tb_ravenoc_out_arbiter.sv
// Directed bench for ravenoc_out_arbiter: per-port source queues, output log, inline checks.
// Define RAVENOC_ARB_TIMEOUT_EN to also exercise the lock watchdog.
module tb_ravenoc_out_arbiter;
  localparam int N   = 5;
  localparam int FW  = 34;
  localparam int VCW = 1;

  logic              clk = 1'b0;
  logic              arst;
  logic [N*FW-1:0]   req_flit_i;
  logic [N*VCW-1:0]  req_vc_i;
  logic [N-1:0]      req_valid_i;
  logic [N-1:0]      req_ready_o;
  logic [FW-1:0]     flit_data_o;
  logic [VCW-1:0]    vc_id_o;
  logic              valid_o;
  logic              ready_i;
  logic [N-1:0]      grant_o;
  logic              busy_o;
`ifdef RAVENOC_ARB_TIMEOUT_EN
  logic              lock_timeout_o;
`endif

  ravenoc_out_arbiter #(
    .N_PORTS(N), .FLIT_WIDTH(FW), .N_VIRT_CHN(2)
`ifdef RAVENOC_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk(clk), .arst(arst),
    .req_flit_i(req_flit_i), .req_vc_i(req_vc_i), .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o), .flit_data_o(flit_data_o), .vc_id_o(vc_id_o),
    .valid_o(valid_o), .ready_i(ready_i), .grant_o(grant_o), .busy_o(busy_o)
`ifdef RAVENOC_ARB_TIMEOUT_EN
    , .lock_timeout_o(lock_timeout_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [FW-1:0]  src_q [N][$];
  logic [VCW-1:0] vc_a [N];
  logic [FW-1:0]  out_log [$];
  logic [N-1:0]   grant_log [$];
  logic [N-1:0]   rdy_snap;

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [31:0] pl);
    return {t, pl};
  endfunction

  // One clock cycle: present queue heads, sample, pop accepted flits, log output handshakes.
  task automatic step();
    logic          fire;
    logic [FW-1:0] dat;
    logic [N-1:0]  g;
    for (int p = 0; p < N; p++) begin
      req_valid_i[p] = (src_q[p].size() > 0);
      if (req_valid_i[p]) req_flit_i[p*FW +: FW] = src_q[p][0];
      else                req_flit_i[p*FW +: FW] = '0;
      req_vc_i[p*VCW +: VCW] = vc_a[p];
    end
    #1;
    rdy_snap = req_ready_o;
    fire     = valid_o && ready_i;
    dat      = flit_data_o;
    g        = grant_o;
    @(posedge clk);
    for (int p = 0; p < N; p++)
      if (req_valid_i[p] && rdy_snap[p]) void'(src_q[p].pop_front());
    if (fire) out_log.push_back(dat);
    grant_log.push_back(g);
    #1;
  endtask

  task automatic apply_reset();
    req_valid_i = '0;
    for (int p = 0; p < N; p++) src_q[p].delete();
    arst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    arst = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({valid_o, busy_o, grant_o, vc_id_o, flit_data_o} !== '0)
      $display("FAIL reset_outputs: got v=%b b=%b g=%b vc=%h d=%h, want all 0",
               valid_o, busy_o, grant_o, vc_id_o, flit_data_o);
    else n_pass++;
    n_checks++;
    if (req_ready_o !== '0) $display("FAIL reset_ready: got %b want 00000", req_ready_o);
    else n_pass++;
    @(posedge clk);
    @(posedge clk);
    #1;
    arst = 1'b1;
  endtask

  task automatic test_single_flit();
    out_log.delete();
    vc_a[2] = 1'b1;
    src_q[2].push_back(mk(2'b11, 32'hABC));
    step();
    n_checks++;
    if (rdy_snap !== 5'b00100) $display("FAIL single_ready: got %b want 00100", rdy_snap);
    else n_pass++;
    n_checks++;
    if (valid_o !== 1'b1 || flit_data_o !== mk(2'b11, 32'hABC) || vc_id_o !== 1'b1)
      $display("FAIL single_out: got v=%b d=%h vc=%b want v=1 d=%h vc=1",
               valid_o, flit_data_o, vc_id_o, mk(2'b11, 32'hABC));
    else n_pass++;
    n_checks++;
    if (busy_o !== 1'b0 || grant_o !== '0)
      $display("FAIL single_nolock: got busy=%b grant=%b want 0/00000", busy_o, grant_o);
    else n_pass++;
    vc_a[2] = 1'b0;
    step();
    n_checks++;
    if (valid_o !== 1'b0) $display("FAIL single_drain: got valid_o=%b want 0", valid_o);
    else n_pass++;
    // Pointer now at 2: P3 must beat P1.
    src_q[1].push_back(mk(2'b11, 32'h10));
    src_q[3].push_back(mk(2'b11, 32'h30));
    step();
    n_checks++;
    if (rdy_snap !== 5'b01000) $display("FAIL rr_after_single: got %b want 01000", rdy_snap);
    else n_pass++;
    step();
    n_checks++;
    if (rdy_snap !== 5'b00010) $display("FAIL rr_second: got %b want 00010", rdy_snap);
    else n_pass++;
    step();
    n_checks++;
    if (out_log.size() !== 3 || out_log[1] !== mk(2'b11, 32'h30) || out_log[2] !== mk(2'b11, 32'h10))
      $display("FAIL single_order: got n=%0d [1]=%h [2]=%h want n=3 %h %h", out_log.size(),
               out_log[1], out_log[2], mk(2'b11, 32'h30), mk(2'b11, 32'h10));
    else n_pass++;
  endtask

  task automatic test_wormhole();
    logic [FW-1:0] exp_d [6];
    logic [N-1:0]  exp_g [7];
    exp_d = '{mk(2'b00, 32'h100), mk(2'b01, 32'h101), mk(2'b10, 32'h102),
              mk(2'b00, 32'h1100), mk(2'b01, 32'h1101), mk(2'b10, 32'h1102)};
    exp_g = '{5'b00000, 5'b00001, 5'b00001, 5'b00000, 5'b00010, 5'b00010, 5'b00000};
    out_log.delete();
    grant_log.delete();
    for (int k = 0; k < 3; k++) begin
      src_q[0].push_back(exp_d[k]);
      src_q[1].push_back(exp_d[k+3]);
    end
    for (int c = 0; c < 7; c++) step();
    n_checks++;
    if (out_log.size() !== 6) $display("FAIL worm_count: got %0d want 6", out_log.size());
    else n_pass++;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (out_log[k] !== exp_d[k]) $display("FAIL worm_flit%0d: got %h want %h", k, out_log[k], exp_d[k]);
      else n_pass++;
    end
    for (int c = 0; c < 7; c++) begin
      n_checks++;
      if (grant_log[c] !== exp_g[c]) $display("FAIL worm_grant%0d: got %b want %b", c, grant_log[c], exp_g[c]);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    out_log.delete();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < N; p++) src_q[p].push_back(mk(2'b11, 32'(p*16 + k)));
    for (int c = 0; c < 11; c++) step();
    n_checks++;
    if (out_log.size() !== 10) $display("FAIL rr_count: got %0d want 10", out_log.size());
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (out_log[i] !== mk(2'b11, 32'((i % N)*16 + i / N)))
        $display("FAIL rr_order%0d: got %h want %h", i, out_log[i], mk(2'b11, 32'((i % N)*16 + i / N)));
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] h, b, t;
    h = mk(2'b00, 32'h0400);
    b = mk(2'b01, 32'h0401);
    t = mk(2'b10, 32'h0402);
    out_log.delete();
    src_q[0].push_back(h);
    src_q[0].push_back(b);
    src_q[0].push_back(t);
    step();
    step();
    ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      n_checks++;
      if (rdy_snap !== '0 || valid_o !== 1'b1 || flit_data_o !== b)
        $display("FAIL bp_hold%0d: got rdy=%b v=%b d=%h want 00000 1 %h", c, rdy_snap, valid_o, flit_data_o, b);
      else n_pass++;
    end
    n_checks++;
    if (busy_o !== 1'b1 || grant_o !== 5'b00001)
      $display("FAIL bp_lock: got busy=%b grant=%b want 1/00001", busy_o, grant_o);
    else n_pass++;
    ready_i = 1'b1;
    step();
    n_checks++;
    if (valid_o !== 1'b1 || flit_data_o !== t || busy_o !== 1'b0)
      $display("FAIL bp_tail: got v=%b d=%h busy=%b want 1 %h 0", valid_o, flit_data_o, busy_o, t);
    else n_pass++;
    step();
    n_checks++;
    if (out_log.size() !== 3 || out_log[0] !== h || out_log[1] !== b || out_log[2] !== t)
      $display("FAIL bp_stream: got n=%0d %h %h %h want 3 %h %h %h", out_log.size(),
               out_log[0], out_log[1], out_log[2], h, b, t);
    else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    src_q[3].push_back(mk(2'b00, 32'h300));
    src_q[3].push_back(mk(2'b01, 32'h301));
    step();
    n_checks++;
    if (busy_o !== 1'b1 || grant_o !== 5'b01000 || valid_o !== 1'b1)
      $display("FAIL mid_locked: got busy=%b grant=%b v=%b want 1 01000 1", busy_o, grant_o, valid_o);
    else n_pass++;
    req_valid_i = '0;
    for (int p = 0; p < N; p++) src_q[p].delete();
    arst = 1'b0;
    #1;
    n_checks++;
    if ({valid_o, busy_o, grant_o, vc_id_o, flit_data_o, req_ready_o} !== '0)
      $display("FAIL mid_reset: got v=%b b=%b g=%b vc=%h d=%h r=%b want all 0",
               valid_o, busy_o, grant_o, vc_id_o, flit_data_o, req_ready_o);
    else n_pass++;
    @(posedge clk);
    #1;
    arst = 1'b1;
    out_log.delete();
    src_q[0].push_back(mk(2'b11, 32'h0A));
    src_q[3].push_back(mk(2'b11, 32'h3A));
    step();
    n_checks++;
    if (rdy_snap !== 5'b00001) $display("FAIL mid_p0_wins: got %b want 00001", rdy_snap);
    else n_pass++;
    step();
    step();
    n_checks++;
    if (out_log.size() !== 2 || out_log[0] !== mk(2'b11, 32'h0A))
      $display("FAIL mid_first_out: got n=%0d %h want 2 %h", out_log.size(), out_log[0], mk(2'b11, 32'h0A));
    else n_pass++;
  endtask

`ifdef RAVENOC_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int  waited;
    bool_seen: begin end
    waited = 0;
    src_q[1].push_back(mk(2'b00, 32'h1F0));
    step();
    src_q[2].push_back(mk(2'b00, 32'h2F0));
    while (lock_timeout_o !== 1'b1 && waited < 40) begin
      step();
      waited++;
    end
    n_checks++;
    if (waited !== 16) $display("FAIL to_latency: got %0d cycles want 16", waited);
    else n_pass++;
    n_checks++;
    if (busy_o !== 1'b0 || grant_o !== '0)
      $display("FAIL to_unlock: got busy=%b grant=%b want 0/00000", busy_o, grant_o);
    else n_pass++;
    step();
    n_checks++;
    if (rdy_snap !== 5'b00100 || lock_timeout_o !== 1'b0 || grant_o !== 5'b00100)
      $display("FAIL to_next_head: got rdy=%b pulse=%b grant=%b want 00100 0 00100",
               rdy_snap, lock_timeout_o, grant_o);
    else n_pass++;
  endtask
`endif

  initial begin
    arst        = 1'b0;
    ready_i     = 1'b1;
    req_valid_i = '0;
    req_flit_i  = '0;
    req_vc_i    = '0;
    for (int p = 0; p < N; p++) vc_a[p] = '0;
    test_reset();
    test_single_flit();
    test_wormhole();
    test_round_robin();
    test_backpressure();
    test_reset_mid_packet();
`ifdef RAVENOC_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
